// File: rtl/radius_scan_sequencer.sv
// Buffers one scan of radius samples, replays it as a single calc_en burst, then returns the captured surface.
// Optional CLOSE_LOOP_EN: burst is SAMPLES+1 long and re-presents sample 0 to close the polygon.
module radius_scan_sequencer #(
    parameter int SAMPLES     = 128,
    parameter int RW          = 16,
    parameter int SW          = 32,
    parameter int CAPTURE_DLY = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [RW-1:0] s_radius,
    output logic          calc_rst,
    output logic          calc_en,
    output logic [RW-1:0] calc_radius,
    input  logic [SW-1:0] calc_surf,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [SW-1:0] m_surf,
    output logic          busy
);

    localparam int CW = $clog2(SAMPLES + 2);
    localparam int AW = (SAMPLES > 1) ? $clog2(SAMPLES) : 1;
`ifdef CLOSE_LOOP_EN
    localparam int BURST = SAMPLES + 1;
`else
    localparam int BURST = SAMPLES;
`endif

    typedef enum logic [2:0] {LOAD, CLEAR, STREAM, DRAIN, RESULT} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] wr_cnt_q, wr_cnt_d;
    logic [CW-1:0] rd_cnt_q, rd_cnt_d;
    logic [3:0]    dly_cnt_q, dly_cnt_d;
    logic          s_ready_q, s_ready_d;
    logic          calc_rst_q, calc_rst_d;
    logic          calc_en_q, calc_en_d;
    logic [RW-1:0] calc_radius_q, calc_radius_d;
    logic          m_valid_q, m_valid_d;
    logic [SW-1:0] m_surf_q, m_surf_d;
    logic          busy_q, busy_d;
    logic          wr_en;
    logic [AW-1:0] rd_addr;

    logic [RW-1:0] sample_mem [SAMPLES];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            sample_mem[wr_cnt_q[AW-1:0]] <= s_radius;
        end
    end

    // calc_radius_q is the read register, so the address leads the presented radius by one cycle
`ifdef CLOSE_LOOP_EN
    assign rd_addr = (rd_cnt_q == CW'(SAMPLES)) ? '0 : rd_cnt_q[AW-1:0];
`else
    assign rd_addr = rd_cnt_q[AW-1:0];
`endif

    always_comb begin
        state_d       = state_q;
        wr_cnt_d      = wr_cnt_q;
        rd_cnt_d      = rd_cnt_q;
        dly_cnt_d     = dly_cnt_q;
        s_ready_d     = s_ready_q;
        calc_rst_d    = calc_rst_q;
        calc_en_d     = calc_en_q;
        calc_radius_d = calc_radius_q;
        m_valid_d     = m_valid_q;
        m_surf_d      = m_surf_q;
        wr_en         = 1'b0;

        case (state_q)
            LOAD: begin
                if (s_valid && s_ready_q) begin
                    wr_en    = 1'b1;
                    wr_cnt_d = wr_cnt_q + 1'b1;
                    if (wr_cnt_q == CW'(SAMPLES - 1)) begin
                        state_d    = CLEAR;
                        s_ready_d  = 1'b0;
                        calc_rst_d = 1'b1;
                    end
                end
            end
            CLEAR: begin
                calc_rst_d    = 1'b0;
                calc_en_d     = 1'b1;
                calc_radius_d = sample_mem[rd_addr];
                rd_cnt_d      = rd_cnt_q + 1'b1;
                state_d       = STREAM;
            end
            STREAM: begin
                if (rd_cnt_q == CW'(BURST)) begin
                    calc_en_d     = 1'b0;
                    calc_radius_d = '0;
                    dly_cnt_d     = 4'd1;
                    state_d       = DRAIN;
                end else begin
                    calc_radius_d = sample_mem[rd_addr];
                    rd_cnt_d      = rd_cnt_q + 1'b1;
                end
            end
            DRAIN: begin
                if (dly_cnt_q == 4'(CAPTURE_DLY)) begin
                    m_surf_d  = calc_surf;
                    m_valid_d = 1'b1;
                    state_d   = RESULT;
                end else begin
                    dly_cnt_d = dly_cnt_q + 1'b1;
                end
            end
            RESULT: begin
                if (m_ready) begin
                    m_valid_d = 1'b0;
                    s_ready_d = 1'b1;
                    wr_cnt_d  = '0;
                    rd_cnt_d  = '0;
                    dly_cnt_d = '0;
                    state_d   = LOAD;
                end
            end
            default: state_d = LOAD;
        endcase

        busy_d = !((state_d == LOAD) && (wr_cnt_d == '0));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= LOAD;
            wr_cnt_q      <= '0;
            rd_cnt_q      <= '0;
            dly_cnt_q     <= '0;
            s_ready_q     <= 1'b1;
            calc_rst_q    <= 1'b0;
            calc_en_q     <= 1'b0;
            calc_radius_q <= '0;
            m_valid_q     <= 1'b0;
            m_surf_q      <= '0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_cnt_q      <= wr_cnt_d;
            rd_cnt_q      <= rd_cnt_d;
            dly_cnt_q     <= dly_cnt_d;
            s_ready_q     <= s_ready_d;
            calc_rst_q    <= calc_rst_d;
            calc_en_q     <= calc_en_d;
            calc_radius_q <= calc_radius_d;
            m_valid_q     <= m_valid_d;
            m_surf_q      <= m_surf_d;
            busy_q        <= busy_d;
        end
    end

    assign s_ready     = s_ready_q;
    assign calc_rst    = calc_rst_q;
    assign calc_en     = calc_en_q;
    assign calc_radius = calc_radius_q;
    assign m_valid     = m_valid_q;
    assign m_surf      = m_surf_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_radius_scan_sequencer.sv
// Directed bench for radius_scan_sequencer: SAMPLES=8, CAPTURE_DLY=4, calculator modelled as a constant surface.
module tb_radius_scan_sequencer;

    localparam int SAMPLES = 8;
    localparam int RW      = 16;
    localparam int SW      = 32;
    localparam int DLY     = 4;
`ifdef CLOSE_LOOP_EN
    localparam int N = SAMPLES + 1;
`else
    localparam int N = SAMPLES;
`endif
    localparam logic [SW-1:0] SURF = 32'hCAFE0001;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [RW-1:0] s_radius = '0;
    logic          calc_rst;
    logic          calc_en;
    logic [RW-1:0] calc_radius;
    logic [SW-1:0] calc_surf = SURF;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [SW-1:0] m_surf;
    logic          busy;

    int tests = 0;
    int fails = 0;
    logic [RW-1:0] radii [SAMPLES];

    always #5 clk = ~clk;

    radius_scan_sequencer #(
        .SAMPLES(SAMPLES), .RW(RW), .SW(SW), .CAPTURE_DLY(DLY)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_radius(s_radius),
        .calc_rst(calc_rst), .calc_en(calc_en), .calc_radius(calc_radius), .calc_surf(calc_surf),
        .m_valid(m_valid), .m_ready(m_ready), .m_surf(m_surf), .busy(busy)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_radii(input int base, input int step);
        for (int i = 0; i < SAMPLES; i++) radii[i] = RW'(base + step * i);
    endtask

    // Feeds radii[]; with gap=1 s_valid alternates 1,0,1,0. Ends on the CLEAR cycle.
    task automatic load_scan(input bit gap);
        int i = 0;
        int guard = 0;
        bit skip = 1'b0;
        while (i < SAMPLES && guard < 200) begin
            @(negedge clk);
            guard++;
            s_valid = 1'b0;
            if (!skip && s_ready) begin
                s_valid  = 1'b1;
                s_radius = radii[i];
                i++;
            end
            skip = gap ? !skip : 1'b0;
        end
        check_eq("load_done", i, SAMPLES);
        @(negedge clk);
        // garbage outside LOAD must be ignored
        s_valid  = 1'b1;
        s_radius = 16'hDEAD;
        check_eq("s_ready_after_last", s_ready, 1'b0);
        check_eq("calc_rst_pulse", calc_rst, 1'b1);
        check_eq("calc_en_in_clear", calc_en, 1'b0);
        check_eq("busy_in_clear", busy, 1'b1);
    endtask

    task automatic stream_check();
        int w = 0;
        for (int k = 0; k < N; k++) begin
            @(negedge clk);
            check_eq("burst_calc_en", calc_en, 1'b1);
            check_eq("burst_calc_rst", calc_rst, 1'b0);
            check_eq("burst_radius", calc_radius, radii[k % SAMPLES]);
            check_eq("burst_s_ready", s_ready, 1'b0);
        end
        @(negedge clk);
        check_eq("post_burst_calc_en", calc_en, 1'b0);
        check_eq("post_burst_radius", calc_radius, 0);
        while (!m_valid && w < 20) begin
            @(negedge clk);
            w++;
        end
        check_eq("capture_delay", w, DLY);
        check_eq("m_surf", m_surf, SURF);
        check_eq("result_s_ready", s_ready, 1'b0);
        check_eq("result_busy", busy, 1'b1);
    endtask

    // Starts on the first RESULT cycle; calc_surf is perturbed to prove m_surf is held.
    task automatic result_handshake(input int hold);
        calc_surf = 32'h12345678;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_eq("hold_m_valid", m_valid, 1'b1);
            check_eq("hold_m_surf", m_surf, SURF);
            check_eq("hold_s_ready", s_ready, 1'b0);
        end
        m_ready = 1'b1;
        s_valid = 1'b0;
        @(negedge clk);
        m_ready = 1'b0;
        calc_surf = SURF;
        check_eq("hs_m_valid", m_valid, 1'b0);
        check_eq("hs_s_ready", s_ready, 1'b1);
        check_eq("hs_busy", busy, 1'b0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_eq("rst_s_ready", s_ready, 1'b1);
        check_eq("rst_calc_rst", calc_rst, 1'b0);
        check_eq("rst_calc_en", calc_en, 1'b0);
        check_eq("rst_calc_radius", calc_radius, 0);
        check_eq("rst_m_valid", m_valid, 1'b0);
        check_eq("rst_m_surf", m_surf, 0);
        check_eq("rst_busy", busy, 1'b0);
        rst_n = 1'b1;

        // continuous valid
        set_radii(10, 10);
        load_scan(1'b0);
        stream_check();
        result_handshake(0);

        // toggling valid
        load_scan(1'b1);
        stream_check();
        result_handshake(0);

        // consumer stall
        set_radii(1000, 7);
        load_scan(1'b0);
        stream_check();
        result_handshake(20);

        // reset on the 4th STREAM cycle
        set_radii(300, 3);
        load_scan(1'b0);
        repeat (4) @(negedge clk);
        check_eq("pre_rst_calc_en", calc_en, 1'b1);
        check_eq("pre_rst_radius", calc_radius, radii[3]);
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_calc_en", calc_en, 1'b0);
        check_eq("async_m_valid", m_valid, 1'b0);
        check_eq("async_s_ready", s_ready, 1'b1);
        check_eq("async_busy", busy, 1'b0);
        s_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        set_radii(500, 11);
        load_scan(1'b0);
        stream_check();
        result_handshake(0);

        // back-to-back scans
        set_radii(100, 100);
        load_scan(1'b0);
        stream_check();
        result_handshake(0);
        set_radii(2000, 5);
        load_scan(1'b0);
        stream_check();
        result_handshake(0);

`ifdef CLOSE_LOOP_EN
        set_radii(5, 1);
        load_scan(1'b0);
        stream_check();
        result_handshake(0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
